// File: rtl/matmul_result_axis_tx.sv
// Snapshots the matmul accumulator bank on the controller's done edge and
// streams it row-major as an AXI4-Stream master, flagging premature re-triggers.
module matmul_result_axis_tx #(
  parameter int unsigned N     = 2,
  parameter int unsigned ACC_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 done,
  input  logic [N*N*ACC_W-1:0] c_flat,
  output logic [ACC_W-1:0]     m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 m_axis_tlast,
  output logic                 busy,
  output logic                 tx_done,
  output logic                 overrun,
  input  logic                 clr_err
);

  localparam int unsigned NE    = N * N;
  localparam int unsigned IDX_W = (NE > 1) ? $clog2(NE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NE - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_FIN  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               done_q, done_d;
  logic [ACC_W-1:0]   shadow_q [NE];
  logic [ACC_W-1:0]   shadow_d [NE];
  logic               overrun_q, overrun_d;
  logic               tvalid_q, tvalid_d;
  logic [ACC_W-1:0]   tdata_q, tdata_d;
  logic               tlast_q, tlast_d;
  logic               busy_q, busy_d;
  logic               tx_done_q, tx_done_d;
  logic               trigger;

  assign trigger = done & ~done_q;

  // State and output registers; outputs are decoded from next state so the
  // stream interface is driven straight from flops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
      tvalid_q  <= 1'b0;
      tdata_q   <= '0;
      tlast_q   <= 1'b0;
      busy_q    <= 1'b0;
      tx_done_q <= 1'b0;
      for (int unsigned e = 0; e < NE; e++) begin
        shadow_q[e] <= '0;
      end
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
      tvalid_q  <= tvalid_d;
      tdata_q   <= tdata_d;
      tlast_q   <= tlast_d;
      busy_q    <= busy_d;
      tx_done_q <= tx_done_d;
      for (int unsigned e = 0; e < NE; e++) begin
        shadow_q[e] <= shadow_d[e];
      end
    end
  end

  // Next-state logic: capture on trigger, advance on handshake.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    done_d    = done;
    overrun_d = overrun_q;
    for (int unsigned e = 0; e < NE; e++) begin
      shadow_d[e] = shadow_q[e];
    end

    unique case (state_q)
      S_IDLE: begin
        if (trigger) begin
          for (int unsigned e = 0; e < NE; e++) begin
            shadow_d[e] = c_flat[e*ACC_W +: ACC_W];
          end
          idx_d   = '0;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (m_axis_tready) begin
          if (idx_q == LAST_IDX) begin
            state_d = S_FIN;
          end else begin
            idx_d = IDX_W'(idx_q + 1'b1);
          end
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
    endcase

    // A new done edge anywhere in the busy window (SEND or FIN) is lost.
    if (trigger && (state_q != S_IDLE)) begin
      overrun_d = 1'b1;
    end else if (clr_err) begin
      overrun_d = 1'b0;
    end
  end

  // Output decode from next state, registered above.
  always_comb begin
    tvalid_d  = (state_d == S_SEND);
    busy_d    = (state_d == S_SEND);
    tx_done_d = (state_d == S_FIN);
    tlast_d   = tvalid_d && (idx_d == LAST_IDX);
    tdata_d   = tvalid_d ? shadow_d[idx_d] : '0;
  end

  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tlast  = tlast_q;
  assign busy          = busy_q;
  assign tx_done       = tx_done_q;
  assign overrun       = overrun_q;

  a_axis_hold: assert property (@(posedge clk) disable iff (!rst_n)
    m_axis_tvalid && !m_axis_tready |=>
      m_axis_tvalid && $stable(m_axis_tdata) && $stable(m_axis_tlast));

  a_tx_done_pulse: assert property (@(posedge clk) disable iff (!rst_n)
    tx_done |=> !tx_done);

  a_idx_range: assert property (@(posedge clk) disable iff (!rst_n)
    m_axis_tvalid |-> (32'(idx_q) < NE));

endmodule

// File: tb/tb_matmul_result_axis_tx.sv
// Bench for matmul_result_axis_tx: directed scenarios plus random traffic,
// checked cycle by cycle against a packet-queue reference model.
module tb_matmul_result_axis_tx;

  localparam int unsigned N     = 2;
  localparam int unsigned ACC_W = 32;
  localparam int unsigned NE    = N * N;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  done;
  logic [NE*ACC_W-1:0]   c_flat;
  logic [ACC_W-1:0]      m_axis_tdata;
  logic                  m_axis_tvalid;
  logic                  m_axis_tready;
  logic                  m_axis_tlast;
  logic                  busy;
  logic                  tx_done;
  logic                  overrun;
  logic                  clr_err;

  int n_checks = 0;
  int n_err    = 0;
  int n_txdone = 0;

  matmul_result_axis_tx #(.N(N), .ACC_W(ACC_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .done          (done),
    .c_flat        (c_flat),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .busy          (busy),
    .tx_done       (tx_done),
    .overrun       (overrun),
    .clr_err       (clr_err)
  );

  always #5 clk = ~clk;

  // Reference model: a packet is the queue of elements not yet accepted.
  logic [ACC_W-1:0] mq[$];
  bit m_fin, m_ovr, m_prev_done;

  always @(posedge clk) begin
    bit trig, in_pkt, was_fin;
    if (!rst_n) begin
      mq.delete();
      m_fin       = 1'b0;
      m_ovr       = 1'b0;
      m_prev_done = 1'b0;
    end else begin
      trig        = done && !m_prev_done;
      m_prev_done = done;
      in_pkt      = (mq.size() != 0);
      was_fin     = m_fin;
      m_fin       = 1'b0;
      if (in_pkt && m_axis_tready) begin
        void'(mq.pop_front());
        if (mq.size() == 0) m_fin = 1'b1;
      end
      if (trig && (in_pkt || was_fin)) begin
        m_ovr = 1'b1;
      end else begin
        if (trig) begin
          for (int e = 0; e < NE; e++) mq.push_back(c_flat[e*ACC_W +: ACC_W]);
        end
        if (clr_err) m_ovr = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Beats accepted by the downstream, reconstructed from the previous sample.
  logic [ACC_W-1:0] got_q[$];
  bit               pv;
  logic [ACC_W-1:0] pd;

  task automatic check_outputs();
    bit ev;
    ev = (mq.size() != 0);
    chk("tvalid",  m_axis_tvalid, ev);
    chk("busy",    busy,          ev);
    chk("tx_done", tx_done,       m_fin);
    chk("overrun", overrun,       m_ovr);
    chk("tlast",   m_axis_tlast,  ev && (mq.size() == 1));
    if (ev) chk("tdata", m_axis_tdata, mq[0]);
    if (pv && m_axis_tready && rst_n) got_q.push_back(pd);
    pv = m_axis_tvalid;
    pd = m_axis_tdata;
    if (tx_done) n_txdone++;
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      check_outputs();
    end
  endtask

  function automatic logic [NE*ACC_W-1:0] mk(input int base);
    logic [NE*ACC_W-1:0] v;
    for (int e = 0; e < NE; e++) v[e*ACC_W +: ACC_W] = ACC_W'(base + e);
    return v;
  endfunction

  task automatic check_pkt(input string tag, input int base);
    chk({tag, "_len"}, got_q.size(), NE);
    for (int e = 0; e < got_q.size() && e < NE; e++)
      chk({tag, "_beat"}, got_q[e], ACC_W'(base + e));
    got_q.delete();
  endtask

  initial begin
    rst_n = 1'b0; done = 1'b0; c_flat = '0; m_axis_tready = 1'b0; clr_err = 1'b0;
    pv = 1'b0; pd = '0;
    step(3);
    chk("rst_tvalid", m_axis_tvalid, 0);
    rst_n = 1'b1;
    step(2);

    // 1: straight packet with tready high
    got_q.delete(); n_txdone = 0;
    c_flat = mk(1); m_axis_tready = 1'b1; done = 1'b1;
    step(1);
    chk("t1_first_valid", m_axis_tvalid, 1);
    chk("t1_first_data", m_axis_tdata, 1);
    step(6);
    check_pkt("t1", 1);
    chk("t1_txdone_cnt", n_txdone, 1);
    chk("t1_busy_after", busy, 0);
    done = 1'b0; step(2);

    // 2: backpressure pattern
    begin
      bit pat [7] = '{1, 0, 0, 1, 0, 1, 1};
      n_txdone = 0; done = 1'b1;
      foreach (pat[i]) begin
        m_axis_tready = pat[i];
        step(1);
      end
      m_axis_tready = 1'b1;
      step(4);
      check_pkt("t2", 1);
      chk("t2_txdone_cnt", n_txdone, 1);
    end
    done = 1'b0; step(2);

    // 3: live bank overwritten right after capture
    c_flat = mk(1); done = 1'b1;
    step(1);
    c_flat = {NE{32'hDEADBEEF}};
    step(6);
    check_pkt("t3", 1);
    done = 1'b0; step(2);

    // 4: done held high produces a single packet
    c_flat = mk(1); n_txdone = 0; done = 1'b1;
    step(20);
    check_pkt("t4a", 1);
    chk("t4a_txdone_cnt", n_txdone, 1);
    done = 1'b0; step(2);
    c_flat = mk(5); done = 1'b1;
    step(6);
    check_pkt("t4b", 5);
    done = 1'b0; step(2);

    // 5: re-trigger during beat 2, then clear
    c_flat = mk(1); done = 1'b1;
    step(2);
    m_axis_tready = 1'b0; done = 1'b0;
    step(1);
    done = 1'b1;
    step(1);
    chk("t5_ovr_set", overrun, 1);
    m_axis_tready = 1'b1;
    step(5);
    check_pkt("t5", 1);
    chk("t5_ovr_held", overrun, 1);
    clr_err = 1'b1; step(1); clr_err = 1'b0;
    chk("t5_ovr_clr", overrun, 0);
    done = 1'b0; step(2);

    // 6: reset mid-stream drops the packet
    n_txdone = 0; c_flat = mk(1); done = 1'b1;
    step(3);
    chk("t6_beat3", m_axis_tdata, 3);
    rst_n = 1'b0; done = 1'b0;
    step(1);
    chk("t6_tvalid", m_axis_tvalid, 0);
    chk("t6_busy", busy, 0);
    chk("t6_txdone", tx_done, 0);
    chk("t6_ovr", overrun, 0);
    step(1);
    rst_n = 1'b1;
    step(6);
    chk("t6_partial_len", got_q.size(), 2);
    chk("t6_no_txdone", n_txdone, 0);
    chk("t6_idle", m_axis_tvalid, 0);
    got_q.delete();

    // Random traffic against the model
    for (int cyc = 0; cyc < 600; cyc++) begin
      m_axis_tready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) done = ~done;
      clr_err = ($urandom_range(0, 9) == 0);
      for (int e = 0; e < NE; e++) c_flat[e*ACC_W +: ACC_W] = $urandom();
      if ($urandom_range(0, 149) == 0) begin
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
      end
      step(1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/matmul_result_axis_tx.md
Name: matmul_result_axis_tx

Overview:
Downstream stage of the matmul controller/datapath pair. On the controller's done level, it snapshots the N×N accumulator result bank. It then streams the results out as an AXI4-Stream master, one element per beat in row-major order, with tlast on the final element. It reports completion and flags results lost to a premature re-trigger.

Parameters:
N, 2, matrix dimension; the stream carries N*N elements per result
ACC_W, 32, accumulator/element width in bits

Ports:
clk  input  1  clock
rst_n  input  1  synchronous active-low reset
done  input  1  controller done level; held high until start drops
c_flat  input  N*N*ACC_W  result bank; element e = c_flat[e*ACC_W +: ACC_W], e = row*N+col
m_axis_tdata  output  ACC_W  result element
m_axis_tvalid  output  1  beat valid
m_axis_tready  input  1  downstream ready
m_axis_tlast  output  1  high on element N*N-1
busy  output  1  high from capture until last handshake
tx_done  output  1  one-cycle pulse after last handshake
overrun  output  1  sticky: new done edge seen while busy
clr_err  input  1  clears overrun

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE, idx=0, done_q=0, shadow=0, all outputs 0.
- done_q is done registered. Trigger is done & !done_q. If done is already high at reset release, that counts as a trigger on the first post-reset cycle.
- FSM IDLE -> SEND -> FIN -> IDLE.
- IDLE:
  - tvalid=0, busy=0.
  - On trigger: shadow <= c_flat, idx <= 0, go to SEND.
  - Latency: trigger sampled at edge t, so tvalid=1 in the cycle after edge t.
- SEND:
  - tvalid=1, busy=1.
  - tdata=shadow element idx, registered or muxed from shadow; never from live c_flat.
  - tlast = (idx == N*N-1).
  - On tvalid&tready: if idx==N*N-1, go to FIN; else idx <= idx+1.
  - Without a handshake, tdata/tlast/tvalid hold stable (AXI rule: tvalid never drops before handshake).
- FIN:
  - tx_done=1 for exactly this cycle, tvalid=0, busy=0.
  - Go to IDLE. idx <= 0.
- Throughput: with tready held high, N*N consecutive beats, then tx_done in the following cycle.
- Snapshot isolation: c_flat changes after capture, e.g. the datapath clears for the next job, must not affect streamed data.
- Re-trigger:
  - A trigger while in SEND or FIN sets overrun. It is ignored; no new capture.
  - A trigger in IDLE on the same cycle FIN exits is not possible. The FIN cycle belongs to the busy window, so a trigger there sets overrun.
  - done held high does not retrigger. The controller only produces a new edge after done falls and a new job completes.
- overrun:
  - Sticky; clr_err=1 clears it.
  - If clr_err and a new overrun event coincide, the set wins.
- idx width: $clog2(N*N), minimum 1 bit.
- Reset mid-stream: on the next edge, the stream aborts immediately with tvalid=0 and no tlast or tx_done is emitted. Downstream must treat this as a dropped packet.
- No combinational path from m_axis_tready to m_axis_tvalid.
- Assertions:
  - tvalid & !tready |=> tvalid & $stable(tdata) & $stable(tlast).
  - tx_done is never high on two consecutive cycles.
  - idx < N*N whenever tvalid.

Test Plan:
1. N=2, ACC_W=32, c_flat={4,3,2,1} (elem0=1), done rises, tready=1 -> beats 1,2,3,4 on 4 consecutive cycles starting the cycle after the trigger edge; tlast only on 4; tx_done one cycle later; busy low afterward.
2. Same data, tready toggles 1,0,0,1,0,1,1 -> every beat is held stable while stalled; the sequence 1,2,3,4 is delivered exactly once; tlast only with 4.
3. c_flat changed to all 0xDEADBEEF one cycle after capture -> stream is still 1,2,3,4.
4. done held high for 20 cycles -> exactly one packet. Then done falls, rises again with c_flat={8,7,6,5} -> second packet 5,6,7,8.
5. done pulses low then high during beat 2 -> overrun=1, packet continues 1..4 unchanged; clr_err=1 -> overrun=0 next cycle.
6. rst_n=0 during beat 3 -> next cycle tvalid=0, busy=0, tx_done=0, overrun=0. With done low, no stream resumes after reset release.
